// File: rtl/data_sram_resp_pkg.sv
// Shared definitions for the data-side SRAM responder and its stall consumers.
package data_sram_resp_pkg;
   // Data SRAM word width.
   localparam int DATA_SRAM_WD = 32;
   // Number of byte lanes in one word.
   localparam int DATA_SRAM_LANES = DATA_SRAM_WD / 8;

   // Stall request encoding shared with the pipeline stall controller.
   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

   // Replace the enabled byte lanes of a word with the matching lanes of the new data.
   function automatic logic [DATA_SRAM_WD-1:0] lane_merge(
      input logic [DATA_SRAM_WD-1:0]    old_w,
      input logic [DATA_SRAM_WD-1:0]    new_w,
      input logic [DATA_SRAM_LANES-1:0] we
   );
      logic [DATA_SRAM_WD-1:0] r;
      r = old_w;
      for (int i = 0; i < DATA_SRAM_LANES; i++)
         if (we[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction
endpackage

// File: rtl/data_sram_resp_ram.sv
// byte_we_ram: 2^ADDR_W x 32 storage with per-lane write enables and a
// registered read-before-write port. Storage itself is never reset.
module byte_we_ram
   import data_sram_resp_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_acc,
   input  logic                       i_clr,
   input  logic [DATA_SRAM_LANES-1:0] i_wen,
   input  logic [ADDR_W-1:0]          i_idx,
   input  logic [DATA_SRAM_WD-1:0]    i_wdata,
   output logic [DATA_SRAM_WD-1:0]    o_rdata
);

   logic [DATA_SRAM_WD-1:0] r_mem [0:(1<<ADDR_W)-1];
   logic [DATA_SRAM_WD-1:0] r_rdata;

   // Commit enabled byte lanes; a cleared (out-of-range) access writes nothing.
   always_ff @(posedge clk) begin
      if (i_acc && !i_clr) begin
         for (int i = 0; i < DATA_SRAM_LANES; i++)
            if (i_wen[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
      end
   end

   // Capture the pre-write word at each access, or zero for a rejected one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        r_rdata <= '0;
      else if (i_acc) r_rdata <= i_clr ? '0 : r_mem[i_idx];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: wait-state counter, range check and stall request in
// front of a byte-write-enable RAM with a one-cycle registered read.
module data_sram_resp
   import data_sram_resp_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       data_sram_en,
   input  logic [DATA_SRAM_LANES-1:0] data_sram_wen,
   input  logic [31:0]                data_sram_addr,
   input  logic [DATA_SRAM_WD-1:0]    data_sram_wdata,
   output logic [DATA_SRAM_WD-1:0]    data_sram_rdata,
   output logic                       stallreq,
   output logic                       range_err
);

   localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

   logic [3:0] r_cnt;
   logic       r_range_err;
   logic       w_access;
   logic       w_oor;
   logic       w_unused_lowaddr;

   // A request only reaches the array once all wait states have elapsed.
   assign w_access = data_sram_en && (r_cnt == WAIT_N);
   // Any set bit above the word index means the address is outside the array.
   assign w_oor    = |data_sram_addr[31:ADDR_W+2];
   // Sub-word selection happens in the memory stage.
   assign w_unused_lowaddr = ^data_sram_addr[1:0];

   assign stallreq = (data_sram_en && (r_cnt < WAIT_N)) ? Stop : NoStop;

   // Wait counter: count while a request waits, restart after access or when the request is withdrawn.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                           r_cnt <= '0;
      else if (!data_sram_en || w_access) r_cnt <= '0;
      else                               r_cnt <= r_cnt + 4'd1;
   end

   // One-cycle error pulse for an access that falls outside the array.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_range_err <= 1'b0;
      else     r_range_err <= w_access && w_oor;
   end

   assign range_err = r_range_err;

   byte_we_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_acc   (w_access),
      .i_clr   (w_oor),
      .i_wen   (data_sram_wen),
      .i_idx   (data_sram_addr[ADDR_W+1:2]),
      .i_wdata (data_sram_wdata),
      .o_rdata (data_sram_rdata)
   );

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench: one responder with no wait states, one with three,
// each compared against a word-array model of the access rules.
module tb_data_sram_resp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en0 = 1'b0, en3 = 1'b0;
   logic [3:0]  wen0 = '0, wen3 = '0;
   logic [31:0] addr0 = '0, addr3 = '0, wd0 = '0, wd3 = '0;
   logic [31:0] rd0, rd3;
   logic        st0, st3, re0, re3;

   int checks = 0;
   int errors = 0;

   logic [31:0] m0 [0:1023];
   logic [31:0] m3 [0:1023];
   logic [31:0] exp_rd0 = '0, exp_rd3 = '0;

   always #5 clk = ~clk;

   data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) u0 (
      .clk(clk), .rst(rst), .data_sram_en(en0), .data_sram_wen(wen0),
      .data_sram_addr(addr0), .data_sram_wdata(wd0),
      .data_sram_rdata(rd0), .stallreq(st0), .range_err(re0));

   data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(3)) u3 (
      .clk(clk), .rst(rst), .data_sram_en(en3), .data_sram_wen(wen3),
      .data_sram_addr(addr3), .data_sram_wdata(wd3),
      .data_sram_rdata(rd3), .stallreq(st3), .range_err(re3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] we);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   // Model of one access: out of range gives 0 and no write, else old word then merge.
   function automatic logic is_oor(input logic [31:0] a);
      return a[31:12] != 20'd0;
   endfunction

   // One cycle on the zero-wait instance; entered and left just after a rising edge.
   task automatic step0(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
      logic exp_re;
      int   idx;
      en0 = e; wen0 = w; addr0 = a; wd0 = d;
      #1 chk("n0_stall", {31'd0, st0}, 32'd0);
      @(posedge clk); #1;
      exp_re = 1'b0;
      if (e) begin
         idx = int'(a[11:2]);
         if (is_oor(a)) begin
            exp_rd0 = '0; exp_re = 1'b1;
         end else begin
            exp_rd0 = m0[idx];
            m0[idx] = merge(m0[idx], d, w);
         end
      end
      chk("n0_rdata", rd0, exp_rd0);
      chk("n0_rerr", {31'd0, re0}, {31'd0, exp_re});
   endtask

   // One full request on the three-wait instance, request still held on exit.
   task automatic acc3(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
      int idx;
      en3 = 1'b1; wen3 = w; addr3 = a; wd3 = d;
      for (int k = 0; k < 3; k++) begin
         #1 chk("n3_wait_stall", {31'd0, st3}, 32'd1);
         @(posedge clk); #1;
         chk("n3_wait_rdata", rd3, exp_rd3);
         chk("n3_wait_rerr", {31'd0, re3}, 32'd0);
      end
      #1 chk("n3_acc_stall", {31'd0, st3}, 32'd0);
      @(posedge clk); #1;
      idx = int'(a[11:2]);
      if (is_oor(a)) exp_rd3 = '0;
      else begin
         exp_rd3 = m3[idx];
         m3[idx] = merge(m3[idx], d, w);
      end
      chk("n3_rdata", rd3, exp_rd3);
      chk("n3_rerr", {31'd0, re3}, {31'd0, is_oor(a)});
      #1 chk("n3_restart_stall", {31'd0, st3}, 32'd1);
   endtask

   // Release the three-wait request for one cycle.
   task automatic idle3();
      en3 = 1'b0;
      #1 chk("n3_idle_stall", {31'd0, st3}, 32'd0);
      @(posedge clk); #1;
      chk("n3_idle_rdata", rd3, exp_rd3);
      chk("n3_idle_rerr", {31'd0, re3}, 32'd0);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = {$urandom_range(1, 1000), 12'h000} | 32'($urandom_range(0, 4095));
      else a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      return a;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rd0", rd0, 32'd0);
      chk("rst_rd3", rd3, 32'd0);
      chk("rst_st3", {31'd0, st3}, 32'd0);
      chk("rst_re0", {31'd0, re0}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Fill the low 64 words of each array with known contents.
      for (int i = 0; i < 64; i++) step0(1'b1, 4'hF, 32'(i) << 2, $urandom);
      step0(1'b0, 4'h0, '0, '0);
      for (int i = 0; i < 64; i++) acc3(4'hF, 32'(i) << 2, $urandom);
      idle3();

      // Asynchronous reset pulse mid-cycle, then read 0x10.
      #2 rst = 1'b1;
      #1 chk("arst_rd0", rd0, 32'd0);
      chk("arst_rd3", rd3, 32'd0);
      exp_rd0 = '0; exp_rd3 = '0;
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("arst_hold", rd0, 32'd0);
      step0(1'b1, 4'h0, 32'h0000_0010, '0);
      chk("rd_0x10", rd0, m0[4]);
      step0(1'b0, 4'h0, '0, '0);

      // Byte-lane writes and read-before-write.
      step0(1'b1, 4'hF, 32'h40, 32'hAABBCCDD);
      step0(1'b1, 4'b0010, 32'h40, 32'h0000_1100);
      chk("rbw_old", rd0, 32'hAABBCCDD);
      step0(1'b1, 4'h0, 32'h40, '0);
      chk("lane_merge", rd0, 32'hAABB11DD);
      step0(1'b0, 4'h0, '0, '0);

      // Out of range with no aliasing.
      step0(1'b1, 4'hF, 32'h0000_1000, 32'h1234_5678);
      chk("oor_rd", rd0, 32'd0);
      chk("oor_err", {31'd0, re0}, 32'd1);
      step0(1'b1, 4'h0, 32'h0, '0);
      chk("oor_noalias", rd0, m0[0]);
      step0(1'b0, 4'h0, '0, '0);

      // Three wait states on a held read of 0x80.
      acc3(4'h0, 32'h80, '0);
      idle3();

      // Flush after two wait cycles: no write, full wait sequence next time.
      en3 = 1'b1; wen3 = 4'hF; addr3 = 32'h80; wd3 = 32'hFEED_F00D;
      repeat (2) begin
         #1 chk("fl_stall", {31'd0, st3}, 32'd1);
         @(posedge clk); #1;
      end
      idle3();
      acc3(4'h0, 32'h80, '0);
      chk("fl_unchanged", rd3 == 32'hFEED_F00D ? 32'd1 : 32'd0, 32'd0);
      idle3();

      // Reset at cnt=2 of a write.
      en3 = 1'b1; wen3 = 4'hF; addr3 = 32'h84; wd3 = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1; en3 = 1'b0;
      #1 chk("rw_stall", {31'd0, st3}, 32'd0);
      chk("rw_rd", rd3, 32'd0);
      exp_rd3 = '0; exp_rd0 = '0;
      #1 rst = 1'b0;
      @(posedge clk); #1;
      acc3(4'h0, 32'h84, '0);
      idle3();

      // Randomized traffic on both instances.
      for (int i = 0; i < 200; i++)
         step0(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
               rand_addr(), $urandom);
      for (int i = 0; i < 25; i++) begin
         acc3(($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, rand_addr(), $urandom);
         if ($urandom_range(0, 1) != 0) idle3();
      end
      idle3();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Data-side memory responder for the five-stage pipeline. It sits on the far end of the data SRAM interface: it accepts enable, byte-write-enable, address and write-data from the execute stage, and returns read data to the memory stage one cycle later. It holds a word-organised storage array and can insert a configurable number of wait states. While wait states are pending it raises a stall request to the pipeline stall controller.

## Interface
- `ADDR_W`, default 10: word-index width; storage depth is 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, default 0: wait states inserted before each access, range 0..15.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `data_sram_en` in 1: access request this cycle.
- `data_sram_wen` in 4: per-byte write enable; bit i writes byte lane i (bits 8i+7:8i). 0 means read.
- `data_sram_addr` in 32: byte address; word index is bits ADDR_W+1:2.
- `data_sram_wdata` in 32: store data, already lane-aligned by execute.
- `data_sram_rdata` out 32: registered read data, full word.
- `stallreq` out 1: combinational; asks the stall controller to freeze the pipeline up to and including execute.
- `range_err` out 1: registered one-cycle pulse for an out-of-range access.

## Operation
- Wait counter `cnt` is 4 bits. The state is IDLE when cnt==0 and WAIT when cnt>0.
- A request is an access when data_sram_en=1 and cnt==WAIT_CYCLES.
- **Access at the rising edge:**
  - If wen!=0, each enabled byte lane of mem[idx] takes the matching wdata lane. Disabled lanes keep their value.
  - data_sram_rdata <= the old mem[idx] (read-before-write), for both reads and writes.
  - cnt <= 0.
- **Request without access:** if data_sram_en=1 and cnt<WAIT_CYCLES, then cnt <= cnt+1, no storage change, and rdata holds its value.
- **No request:** if data_sram_en=0, cnt <= 0 and rdata holds. A request withdrawn mid-WAIT (flush) aborts with no access.
- **stallreq** = data_sram_en & (cnt < WAIT_CYCLES). It is constantly 0 when WAIT_CYCLES=0.
- **Range check:** out of range means addr[31:ADDR_W+2] != 0.
  - At the access edge, range_err <= 1, the write is suppressed and rdata <= 0.
  - range_err is 0 at every other edge.
- addr[1:0] is ignored. The memory stage performs sub-word byte/half selection and sign extension.
- **Reset values:** rdata=0, stallreq=0 (cnt=0), range_err=0. Storage contents are not reset. Reset asserted mid-WAIT drops the pending request.

## Timing
- With WAIT_CYCLES=N, a request held steady from cycle 0:
  - stallreq is 1 in cycles 0..N-1 and 0 in cycle N.
  - The access occurs at the edge ending cycle N.
  - rdata and range_err are valid in cycle N+1.
- With N=0: the request in cycle k gives rdata in cycle k+1 with no stall.
- Back-to-back requests with N=0 are each serviced in one cycle.
- With N>0 each request re-enters the wait sequence, because cnt returns to 0 after the access.
- The execute stage holds en/wen/addr/wdata stable while stallreq=1. The block samples them only at the access edge.
- A write followed by a read of the same word in the next cycle returns the new data. No bypass is needed because the write commits at the earlier edge.

## Structure
- Shared defines header: `DATA_SRAM_WD` and a `Stop`/`NoStop`-style stall encoding for stallreq consumers.
- Natural sub-module: `byte_we_ram`, a 2^ADDR_W x 32 array with 4 byte-lane write enables and a registered read port.
- The counter, range check and stallreq logic stay in the top module.

## Test plan
- **Reset then read, N=0:** pulse rst mid-cycle (asynchronous), then read addr 0x0000_0010 → rdata=0 at reset, then the stored word one cycle after the request. stallreq stays 0.
- **Byte-lane write, N=0:**
  - Write 0xAABBCCDD with wen=4'hF at 0x40.
  - Then write 0x0000_1100 with wen=4'b0010.
  - Then read 0x40 → 0xAABB11DD. The second write's own rdata is 0xAABBCCDD (read-before-write).
- **Wait states, N=3:** hold a read of 0x80 → stallreq high for exactly 3 cycles, low in cycle 3, rdata valid in cycle 4. A single access is performed.
- **Flush mid-wait, N=3:**
  - Issue a write and drop en after 2 cycles → memory unchanged, cnt back to 0, stallreq low.
  - The next request needs a full 3 wait cycles again.
- **Out of range, ADDR_W=10:** write to 0x0000_1000 → range_err=1 for one cycle, rdata=0. A following read of 0x0 shows the word unchanged, with no aliasing write.
- **Reset mid-wait:** assert rst during cnt=2 of a write → stallreq drops immediately, the write is never performed, and rdata=0.
